// File: rtl/sprite_blitter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sprite_blitter_pkg
// Description : Shared mode encoding, FSM state type and screen defaults
//               for the sprite blitter.
// Revision    : 1.0 - initial release
// ============================================================================
package sprite_blitter_pkg;

  localparam logic        MODE_FILL    = 1'b0;
  localparam logic        MODE_SPRITE  = 1'b1;
  localparam int          SCREEN_W_DEF = 320;
  localparam int          SCREEN_H_DEF = 240;
  localparam logic [11:0] BG_COLOUR    = 12'h884;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/blit_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : blit_delay_line
// Description : DEPTH-stage shift register that keeps generated pixels in
//               step with the sprite ROM read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module blit_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];

  always_comb begin
    valid_d[0] = in_valid;
    data_d[0]  = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      data_d[i]  = data_q[i-1];
    end
  end

  // Only the valid bits need reset; payload is ignored while invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
    data_q <= data_d;
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/sprite_blitter.sv
`default_nettype none
// ============================================================================
// Module      : sprite_blitter
// Description : Rectangle fill / ROM sprite blitter producing one plot per
//               cycle for a VGA adapter, with colour keying and clipping.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_blitter
  import sprite_blitter_pkg::*;
#(
  parameter int X_W      = 9,
  parameter int Y_W      = 8,
  parameter int COLOUR_W = 12,
  parameter int ADDR_W   = 17,
  parameter int SIZE_W   = 7,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int ROM_LAT  = 1
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_mode,
  input  logic [X_W-1:0]      cmd_x,
  input  logic [Y_W-1:0]      cmd_y,
  input  logic [SIZE_W-1:0]   cmd_w,
  input  logic [SIZE_W-1:0]   cmd_h,
  input  logic [COLOUR_W-1:0] cmd_colour,
  input  logic [ADDR_W-1:0]   cmd_base,
  input  logic                cmd_key_en,
  input  logic [COLOUR_W-1:0] cmd_key,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0] rom_data,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  localparam int          DL_W  = X_W + Y_W + 1 + COLOUR_W;
  localparam logic [X_W:0] SCR_W = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SCR_H = (Y_W+1)'(SCREEN_H);

  state_t                state_q, state_d;
  logic                  mode_q, mode_d, key_en_q, key_en_d, done_q, done_d;
  logic [COLOUR_W-1:0]   key_q, key_d, fill_q, fill_d;
  logic [X_W-1:0]        x0_q, x0_d;
  logic [SIZE_W-1:0]     w_q, w_d, h_q, h_d, col_q, col_d, row_q, row_d;
  logic [X_W:0]          cx_q, cx_d;
  logic [Y_W:0]          cy_q, cy_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [1:0]            drain_q, drain_d;
  logic [X_W-1:0]        x_hold_q, x_hold_d;
  logic [Y_W-1:0]        y_hold_q, y_hold_d;
  logic [COLOUR_W-1:0]   c_hold_q, c_hold_d;
  logic                  gen_valid, gen_inside, dl_valid, key_hit;
  logic [DL_W-1:0]       dl_in, dl_out;
  logic [X_W-1:0]        tail_x;
  logic [Y_W-1:0]        tail_y;
  logic                  tail_inside;
  logic [COLOUR_W-1:0]   tail_colour, pix_colour;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    key_en_d  = key_en_q;
    key_d     = key_q;
    fill_d    = fill_q;
    x0_d      = x0_q;
    w_d       = w_q;
    h_d       = h_q;
    col_d     = col_q;
    row_d     = row_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    addr_d    = addr_q;
    drain_d   = drain_q;
    done_d    = 1'b0;
    gen_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          mode_d   = cmd_mode;
          key_en_d = cmd_key_en;
          key_d    = cmd_key;
          fill_d   = cmd_colour;
          x0_d     = cmd_x;
          w_d      = cmd_w;
          h_d      = cmd_h;
          col_d    = '0;
          row_d    = '0;
          cx_d     = {1'b0, cmd_x};
          cy_d     = {1'b0, cmd_y};
          addr_d   = cmd_base;
          if (cmd_w == '0 || cmd_h == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        // Row-major raster: the address simply counts, no multiply needed.
        gen_valid = 1'b1;
        addr_d    = addr_q + 1'b1;
        if (col_q == w_q - 1'b1) begin
          col_d = '0;
          cx_d  = {1'b0, x0_q};
          row_d = row_q + 1'b1;
          cy_d  = cy_q + 1'b1;
          if (row_q == h_q - 1'b1) begin
            state_d = DRAIN;
            drain_d = 2'(ROM_LAT);
          end
        end else begin
          col_d = col_q + 1'b1;
          cx_d  = cx_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == 2'd1) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Extra coordinate bit catches pixels that wrap past the coordinate range.
  assign gen_inside = (cx_q < SCR_W) && (cy_q < SCR_H);
  assign dl_in      = {cx_q[X_W-1:0], cy_q[Y_W-1:0], gen_inside, fill_q};

  blit_delay_line #(
    .DEPTH (ROM_LAT),
    .WIDTH (DL_W)
  ) u_delay (
    .clk       (CLOCK_50),
    .rst       (reset),
    .in_valid  (gen_valid),
    .in_data   (dl_in),
    .out_valid (dl_valid),
    .out_data  (dl_out)
  );

  assign tail_x      = dl_out[DL_W-1 -: X_W];
  assign tail_y      = dl_out[COLOUR_W+1 +: Y_W];
  assign tail_inside = dl_out[COLOUR_W];
  assign tail_colour = dl_out[COLOUR_W-1:0];

  assign key_hit    = (mode_q == MODE_SPRITE) && key_en_q && (rom_data == key_q);
  assign pix_colour = (mode_q == MODE_SPRITE) ? rom_data : tail_colour;
  assign plot       = dl_valid && tail_inside && !key_hit && !reset;

  always_comb begin
    x_hold_d = x_hold_q;
    y_hold_d = y_hold_q;
    c_hold_d = c_hold_q;
    if (plot) begin
      x_hold_d = tail_x;
      y_hold_d = tail_y;
      c_hold_d = pix_colour;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= IDLE;
      mode_q   <= MODE_FILL;
      key_en_q <= 1'b0;
      key_q    <= '0;
      fill_q   <= '0;
      x0_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      col_q    <= '0;
      row_q    <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      addr_q   <= '0;
      drain_q  <= '0;
      done_q   <= 1'b0;
      x_hold_q <= '0;
      y_hold_q <= '0;
      c_hold_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      key_en_q <= key_en_d;
      key_q    <= key_d;
      fill_q   <= fill_d;
      x0_q     <= x0_d;
      w_q      <= w_d;
      h_q      <= h_d;
      col_q    <= col_d;
      row_q    <= row_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      addr_q   <= addr_d;
      drain_q  <= drain_d;
      done_q   <= done_d;
      x_hold_q <= x_hold_d;
      y_hold_q <= y_hold_d;
      c_hold_q <= c_hold_d;
    end
  end

  assign cmd_ready = (state_q == IDLE) && !reset;
  assign busy      = (state_q != IDLE) && !reset;
  assign done      = done_q && !reset;
  assign rom_addr  = addr_q;
  assign x         = plot ? tail_x      : x_hold_q;
  assign y         = plot ? tail_y      : y_hold_q;
  assign colour    = plot ? pix_colour  : c_hold_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_blitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_blitter
// Description : Self-checking bench for sprite_blitter at ROM_LAT 1 and 3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_blitter;

  typedef struct {
    int mode; int x; int y; int w; int h; int colour; int base; int key_en; int key;
  } cmd_t;
  typedef struct packed { int cyc; int x; int y; int col; } pix_t;

  logic        clk, reset;
  logic [1:0]  cv, rdy, busy_v, plot_v, done_v;
  logic        c_mode, c_key_en;
  logic [8:0]  c_x;
  logic [7:0]  c_y;
  logic [6:0]  c_w, c_h;
  logic [11:0] c_colour, c_key;
  logic [16:0] c_base;
  logic [16:0] ra_v [2];
  logic [11:0] rd_v [2];
  logic [8:0]  x_v  [2];
  logic [7:0]  y_v  [2];
  logic [11:0] col_v[2];
  logic [11:0] p1 [2], p2 [2], p3 [2];
  logic [11:0] rom_mem [0:131071];

  int   total, bad, cyc, mon_sel;
  pix_t got_q[$], exp_q[$], mon_p;
  int   done_q[$];

  sprite_blitter #(.ROM_LAT(1)) u_dut1 (
    .CLOCK_50(clk), .reset(reset), .cmd_valid(cv[0]), .cmd_ready(rdy[0]),
    .cmd_mode(c_mode), .cmd_x(c_x), .cmd_y(c_y), .cmd_w(c_w), .cmd_h(c_h),
    .cmd_colour(c_colour), .cmd_base(c_base), .cmd_key_en(c_key_en), .cmd_key(c_key),
    .rom_addr(ra_v[0]), .rom_data(rd_v[0]), .x(x_v[0]), .y(y_v[0]), .colour(col_v[0]),
    .plot(plot_v[0]), .busy(busy_v[0]), .done(done_v[0]));

  sprite_blitter #(.ROM_LAT(3)) u_dut3 (
    .CLOCK_50(clk), .reset(reset), .cmd_valid(cv[1]), .cmd_ready(rdy[1]),
    .cmd_mode(c_mode), .cmd_x(c_x), .cmd_y(c_y), .cmd_w(c_w), .cmd_h(c_h),
    .cmd_colour(c_colour), .cmd_base(c_base), .cmd_key_en(c_key_en), .cmd_key(c_key),
    .rom_addr(ra_v[1]), .rom_data(rd_v[1]), .x(x_v[1]), .y(y_v[1]), .colour(col_v[1]),
    .plot(plot_v[1]), .busy(busy_v[1]), .done(done_v[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM with registered read, 1 or 3 cycles deep.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      p1[i] <= rom_mem[ra_v[i]];
      p2[i] <= p1[i];
      p3[i] <= p2[i];
    end
  end
  assign rd_v[0] = p1[0];
  assign rd_v[1] = p3[1];

  always @(negedge clk) begin
    if (!reset && plot_v[mon_sel]) begin
      mon_p.cyc = cyc;
      mon_p.x   = int'(x_v[mon_sel]);
      mon_p.y   = int'(y_v[mon_sel]);
      mon_p.col = int'(col_v[mon_sel]);
      got_q.push_back(mon_p);
    end
    if (!reset && done_v[mon_sel]) done_q.push_back(cyc);
  end

  // Reference: every pixel of the rectangle in raster order, first one
  // 1+L cycles after acceptance; returns the expected done cycle.
  function automatic int model(input cmd_t c, input int acc, input int lat);
    int idx, px, py, word;
    pix_t p;
    for (int r = 0; r < c.h; r++) begin
      for (int k = 0; k < c.w; k++) begin
        idx  = r * c.w + k;
        px   = c.x + k;
        py   = c.y + r;
        word = int'(rom_mem[(c.base + idx) % 131072]);
        if (px < 320 && py < 240 && !(c.mode == 1 && c.key_en == 1 && word == c.key)) begin
          p.cyc = acc + 1 + lat + idx;
          p.x   = px;
          p.y   = py;
          p.col = (c.mode == 1) ? word : c.colour;
          exp_q.push_back(p);
        end
      end
    end
    return (c.w * c.h == 0) ? acc + 1 : acc + c.w * c.h + lat + 1;
  endfunction

  task automatic clear_logs();
    got_q.delete();
    exp_q.delete();
    done_q.delete();
  endtask

  task automatic send(input int s, input cmd_t c, output int acc);
    @(posedge clk); #1;
    c_mode = c.mode[0]; c_x = c.x[8:0]; c_y = c.y[7:0]; c_w = c.w[6:0]; c_h = c.h[6:0];
    c_colour = c.colour[11:0]; c_base = c.base[16:0]; c_key_en = c.key_en[0]; c_key = c.key[11:0];
    cv[s] = 1'b1;
    acc = -1;
    for (int i = 0; i < 3000 && acc < 0; i++) begin
      @(negedge clk);
      if (rdy[s]) acc = cyc;
    end
    @(posedge clk); #1;
    cv[s] = 1'b0;
    // Scramble the fields: a running command must not notice.
    c_x = 9'($urandom); c_y = 8'($urandom); c_w = 7'($urandom); c_h = 7'($urandom);
    c_colour = 12'($urandom); c_base = 17'($urandom); c_key = 12'($urandom);
    c_mode = 1'($urandom); c_key_en = 1'($urandom);
    if (acc < 0) begin
      total++; bad++;
      $display("FAIL send_timeout dut=%0d got=no_accept required=accept", s);
    end
  endtask

  task automatic wait_done(input int n, input string nm);
    int i;
    i = 0;
    while (done_q.size() < n && i < 3000) begin
      @(negedge clk);
      i++;
    end
    if (done_q.size() < n) begin
      total++; bad++;
      $display("FAIL %s_timeout got_done=%0d required=%0d", nm, done_q.size(), n);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total += 4;
    if (plot_v !== 2'b00)  begin bad++; $display("FAIL rst_plot got=%b required=00", plot_v); end
    if (done_v !== 2'b00)  begin bad++; $display("FAIL rst_done got=%b required=00", done_v); end
    if (busy_v !== 2'b00)  begin bad++; $display("FAIL rst_busy got=%b required=00", busy_v); end
    if (rdy !== 2'b00)     begin bad++; $display("FAIL rst_ready got=%b required=00", rdy); end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      total += 5;
      if (rdy[s] !== 1'b1 || busy_v[s] !== 1'b0) begin
        bad++; $display("FAIL post_rst_hs dut=%0d got=%b%b required=10", s, rdy[s], busy_v[s]);
      end
      if (x_v[s] !== 9'd0)    begin bad++; $display("FAIL post_rst_x got=%0d required=0", x_v[s]); end
      if (y_v[s] !== 8'd0)    begin bad++; $display("FAIL post_rst_y got=%0d required=0", y_v[s]); end
      if (col_v[s] !== 12'd0) begin bad++; $display("FAIL post_rst_col got=%h required=0", col_v[s]); end
      if (ra_v[s] !== 17'd0)  begin bad++; $display("FAIL post_rst_addr got=%0d required=0", ra_v[s]); end
    end
  endtask

  task automatic test_fill(input int s);
    cmd_t c;
    int   acc, dn, lat;
    lat = (s == 0) ? 1 : 3;
    clear_logs();
    c = '{mode:0, x:10, y:20, w:3, h:2, colour:12'hF00, base:0, key_en:1, key:12'hF00};
    send(s, c, acc);
    @(negedge clk);
    total++;
    if (busy_v[s] !== 1'b1 || rdy[s] !== 1'b0) begin
      bad++; $display("FAIL fill_busy dut=%0d got=%b%b required=10", s, busy_v[s], rdy[s]);
    end
    dn = model(c, acc, lat);
    wait_done(1, "fill");
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL fill_count dut=%0d got=%0d required=%0d", s, got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL fill_pix%0d got=%h required=%h", i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if (done_q.size() != 1 || done_q[0] != dn) begin
      bad++; $display("FAIL fill_done dut=%0d got_n=%0d required_cycle=%0d", s, done_q.size(), dn);
    end
  endtask

  task automatic test_sprite_key(input int s);
    cmd_t c;
    int   acc, dn, lat;
    lat = (s == 0) ? 1 : 3;
    clear_logs();
    c = '{mode:1, x:50, y:60, w:4, h:4, colour:0, base:256, key_en:1, key:12'hFFF};
    send(s, c, acc);
    dn = model(c, acc, lat);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      total++;
      if (ra_v[s] !== 17'(256 + k)) begin
        bad++; $display("FAIL key_addr%0d got=%0d required=%0d", k, ra_v[s], 256 + k);
      end
      if (k == lat + 5) begin
        total++;
        if (plot_v[s] !== 1'b0 || x_v[s] !== 9'd50 || y_v[s] !== 8'd61 || col_v[s] !== rom_mem[260]) begin
          bad++; $display("FAIL key_hold got=%b,%0d,%0d,%h required=0,50,61,%h",
                          plot_v[s], x_v[s], y_v[s], col_v[s], rom_mem[260]);
        end
      end
    end
    wait_done(1, "key");
    total++;
    if (got_q.size() != 15 || exp_q.size() != 15) begin
      bad++; $display("FAIL key_count dut=%0d got=%0d required=15", s, got_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL key_pix%0d got=%h required=%h", i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if (done_q.size() != 1 || done_q[0] != dn) begin
      bad++; $display("FAIL key_done dut=%0d got_n=%0d required_cycle=%0d", s, done_q.size(), dn);
    end
  endtask

  task automatic test_clip(input int s);
    cmd_t c [2];
    int   acc, dn, lat;
    lat  = (s == 0) ? 1 : 3;
    c[0] = '{mode:0, x:318, y:238, w:4, h:4, colour:12'h0A5, base:0, key_en:0, key:0};
    c[1] = '{mode:1, x:510, y:5, w:4, h:2, colour:0, base:9000, key_en:0, key:0};
    for (int j = 0; j < 2; j++) begin
      clear_logs();
      send(s, c[j], acc);
      dn = model(c[j], acc, lat);
      wait_done(1, "clip");
      total++;
      if (got_q.size() != exp_q.size() || got_q.size() != ((j == 0) ? 4 : 0)) begin
        bad++; $display("FAIL clip_count%0d dut=%0d got=%0d required=%0d", j, s, got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
        total++;
        if (got_q[i] !== exp_q[i]) begin
          bad++; $display("FAIL clip_pix%0d got=%h required=%h", i, got_q[i], exp_q[i]);
        end
      end
      total++;
      if (done_q.size() != 1 || done_q[0] != acc + 16 * (j == 0 ? 1 : 0) + 8 * j + lat + 1) begin
        bad++; $display("FAIL clip_done%0d dut=%0d got_n=%0d required_cycle=%0d", j, s, done_q.size(), dn);
      end
    end
  endtask

  task automatic test_zero(input int s);
    cmd_t c;
    int   acc;
    for (int j = 0; j < 2; j++) begin
      clear_logs();
      c = '{mode:j, x:20, y:20, w:(j == 0) ? 0 : 5, h:(j == 0) ? 3 : 0, colour:12'h111,
            base:40, key_en:0, key:0};
      send(s, c, acc);
      @(negedge clk);
      total++;
      if (done_v[s] !== 1'b1 || rdy[s] !== 1'b1 || busy_v[s] !== 1'b0) begin
        bad++; $display("FAIL zero_done%0d dut=%0d got=%b%b%b required=110", j, s, done_v[s], rdy[s], busy_v[s]);
      end
      repeat (6) @(negedge clk);
      total++;
      if (got_q.size() != 0 || done_q.size() != 1 || done_q[0] != acc + 1) begin
        bad++; $display("FAIL zero_quiet%0d dut=%0d got_plots=%0d got_dones=%0d required=0,1", j, s, got_q.size(), done_q.size());
      end
    end
  endtask

  task automatic test_random(input int s);
    cmd_t c;
    int   acc, dn, lat;
    lat = (s == 0) ? 1 : 3;
    for (int n = 0; n < 8; n++) begin
      clear_logs();
      c.mode   = int'($urandom_range(0, 1));
      c.w      = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
      c.h      = int'($urandom_range(1, 6));
      c.x      = ($urandom_range(0, 1) == 1) ? int'($urandom_range(300, 511)) : int'($urandom_range(0, 299));
      c.y      = ($urandom_range(0, 1) == 1) ? int'($urandom_range(230, 255)) : int'($urandom_range(0, 229));
      c.colour = int'($urandom_range(0, 4095));
      c.base   = int'($urandom_range(0, 131071));
      c.key_en = int'($urandom_range(0, 1));
      c.key    = ($urandom_range(0, 1) == 1) ? int'(rom_mem[(c.base + int'($urandom_range(0, 5))) % 131072])
                                             : int'($urandom_range(0, 4095));
      send(s, c, acc);
      dn = model(c, acc, lat);
      wait_done(1, "rand");
      total++;
      if (got_q.size() != exp_q.size()) begin
        bad++; $display("FAIL rand%0d_count dut=%0d got=%0d required=%0d", n, s, got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
        total++;
        if (got_q[i] !== exp_q[i]) begin
          bad++; $display("FAIL rand%0d_pix%0d got=%h required=%h", n, i, got_q[i], exp_q[i]);
        end
      end
      total++;
      if (done_q.size() != 1 || done_q[0] != dn) begin
        bad++; $display("FAIL rand%0d_done dut=%0d got_n=%0d required_cycle=%0d", n, s, done_q.size(), dn);
      end
    end
  endtask

  task automatic test_back_to_back(input int s);
    cmd_t c1, c2;
    int   a1, a2, d1, d2, lat;
    lat = (s == 0) ? 1 : 3;
    clear_logs();
    c1 = '{mode:1, x:100, y:100, w:int'($urandom_range(3, 6)), h:int'($urandom_range(2, 3)),
           colour:0, base:int'($urandom_range(0, 100000)), key_en:0, key:0};
    c2 = '{mode:0, x:200, y:10, w:2, h:2, colour:12'h5C3, base:0, key_en:0, key:0};
    send(s, c1, a1);
    send(s, c2, a2);
    d1 = model(c1, a1, lat);
    d2 = model(c2, a2, lat);
    wait_done(2, "b2b");
    total += 2;
    if (a2 != d1) begin
      bad++; $display("FAIL b2b_accept dut=%0d got=%0d required=%0d", s, a2, d1);
    end
    if (got_q.size() == 0 || got_q[0].cyc - a1 != 1 + lat) begin
      bad++; $display("FAIL b2b_latency dut=%0d got_plots=%0d required_latency=%0d", s, got_q.size(), 1 + lat);
    end
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL b2b_count dut=%0d got=%0d required=%0d", s, got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL b2b_pix%0d got=%h required=%h", i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if (done_q.size() != 2 || done_q[0] != d1 || done_q[1] != d2) begin
      bad++; $display("FAIL b2b_done dut=%0d got_n=%0d required=%0d,%0d", s, done_q.size(), d1, d2);
    end
  endtask

  task automatic test_reset_abort(input int s);
    cmd_t c;
    int   acc, dn, lat, seen;
    lat = (s == 0) ? 1 : 3;
    clear_logs();
    c = '{mode:1, x:40, y:30, w:16, h:16, colour:0, base:1000, key_en:0, key:0};
    send(s, c, acc);
    seen = 0;
    for (int i = 0; i < 200 && seen < 3; i++) begin
      @(negedge clk);
      if (plot_v[s]) seen++;
    end
    total++;
    if (seen != 3) begin bad++; $display("FAIL abort_start dut=%0d got=%0d required=3", s, seen); end
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      total++;
      if (plot_v[s] !== 1'b0) begin bad++; $display("FAIL abort_plot_rst dut=%0d got=1 required=0", s); end
    end
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (plot_v[s] !== 1'b0 || done_v[s] !== 1'b0) begin
        bad++; $display("FAIL abort_quiet dut=%0d got=%b%b required=00", s, plot_v[s], done_v[s]);
      end
    end
    clear_logs();
    c = '{mode:1, x:100, y:50, w:5, h:3, colour:0, base:5000, key_en:0, key:0};
    send(s, c, acc);
    dn = model(c, acc, lat);
    wait_done(1, "abort");
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL abort_count dut=%0d got=%0d required=%0d", s, got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL abort_pix%0d got=%h required=%h", i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if (done_q.size() != 1 || done_q[0] != dn) begin
      bad++; $display("FAIL abort_done dut=%0d got_n=%0d required_cycle=%0d", s, done_q.size(), dn);
    end
  endtask

  initial begin
    total = 0; bad = 0; mon_sel = 0;
    reset = 1'b1; cv = 2'b00;
    c_mode = 1'b0; c_x = '0; c_y = '0; c_w = '0; c_h = '0;
    c_colour = '0; c_base = '0; c_key_en = 1'b0; c_key = '0;
    for (int a = 0; a < 131072; a++) rom_mem[a] = 12'($urandom);
    for (int a = 256; a < 272; a++) if (rom_mem[a] == 12'hFFF) rom_mem[a] = 12'h123;
    rom_mem[261] = 12'hFFF;
    test_reset();
    for (int s = 0; s < 2; s++) begin
      mon_sel = s;
      test_fill(s);
      test_sprite_key(s);
      test_clip(s);
      test_zero(s);
      test_random(s);
      test_back_to_back(s);
      test_reset_abort(s);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
